// File: rtl/work_loader_pkg.sv
// work_loader_pkg: shared state encoding, packet geometry and buffer offsets
// for the work loader and its inter-byte timer.
`timescale 1ns/1ps
package work_loader_pkg;

    // Loader FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        COMMIT = 2'd2,
        START  = 2'd3
    } wl_state_e;

    // Default packet size in bytes.
    localparam int WORK_BYTES_DEF = 64;

    // Assembly buffer geometry: byte k lives at bits [8k+7:8k].
    localparam int BUF_BYTES = 64;
    localparam int BUF_IDX_W = 6;
    localparam int BUF_W     = 8 * BUF_BYTES;

    // Fields committed to the hashing core. Bytes 32..51 are never used.
    localparam int MIDSTATE_LSB = 0;
    localparam int MIDSTATE_W   = 256;
    localparam int DATA2_LSB    = 416;
    localparam int DATA2_W      = 96;

    // Width of the inter-byte idle counter.
    localparam int TIMER_W = 24;

endpackage

// File: rtl/work_loader_if.sv
// work_loader_if: byte stream in, committed work and status out.
// master = UART side / system, slave = the loader.
`timescale 1ns/1ps
interface work_loader_if;
    import work_loader_pkg::*;

    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  miner_busy;
    logic [MIDSTATE_W-1:0] midstate;
    logic [DATA2_W-1:0]    data2;
    logic                  start_mining;
    logic                  loader_busy;
    logic                  work_dropped;

    modport master (
        output rx_data, rx_valid, miner_busy,
        input  midstate, data2, start_mining, loader_busy, work_dropped
    );

    modport slave (
        input  rx_data, rx_valid, miner_busy,
        output midstate, data2, start_mining, loader_busy, work_dropped
    );

endinterface

// File: rtl/work_rx_timer.sv
// work_rx_timer: counts idle cycles while enabled; expired is high in the
// cycle where TIMEOUT_CYCLES idle cycles have elapsed since the last restart.
// Only instantiated when WORK_LOADER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module work_rx_timer
    import work_loader_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 24'd10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] tcnt;

    // Expiry does not depend on restart so a byte in the expiry cycle still
    // sees the drop and starts a fresh packet.
    assign expired = enable && (tcnt == TIMEOUT_CYCLES - 1'b1);

    // Idle counter: cleared on restart, saturates at expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (restart) begin
            tcnt <= '0;
        end else if (enable && !expired) begin
            tcnt <= tcnt + 1'b1;
        end
    end

endmodule

// File: rtl/work_loader.sv
// work_loader: assembles WORK_BYTES UART bytes into a work packet, commits
// midstate/data2 atomically, then pulses start_mining for START_HOLD cycles.
// Bytes arriving during the start hold are kept as the head of the next packet.
// Optional inter-byte timeout: define WORK_LOADER_TIMEOUT_EN.
`timescale 1ns/1ps
module work_loader
    import work_loader_pkg::*;
#(
    parameter int                 WORK_BYTES     = WORK_BYTES_DEF,
    parameter int                 START_HOLD     = 4,
    parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 24'd10000000
) (
    input  logic         clk,
    input  logic         rst,
    work_loader_if.slave bus
);

    localparam int                CNT_W     = $clog2(WORK_BYTES) + 1;
    localparam int                HOLD_W    = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORK_BYTES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);

    wl_state_e                 state;
    logic [CNT_W-1:0]          cnt;
    logic [HOLD_W-1:0]         hold_cnt;
    logic [BUF_BYTES-1:0][7:0] asm_buf;
    logic [MIDSTATE_W-1:0]     midstate_q;
    logic [DATA2_W-1:0]        data2_q;
    logic                      start_q;
    logic                      busy_q;

    logic [BUF_IDX_W-1:0]      wr_idx;
    logic [CNT_W-1:0]          cnt_inc;
    logic [BUF_W-1:0]          buf_flat;
    logic                      take_start;
    logic [CNT_W-1:0]          cnt_start;

    // Write pointer, next count, and the count after a byte taken during START.
    always_comb begin
        wr_idx     = BUF_IDX_W'(cnt);
        cnt_inc    = cnt + 1'b1;
        buf_flat   = asm_buf;
        take_start = bus.rx_valid && (cnt != CNT_FULL);
        cnt_start  = take_start ? cnt_inc : cnt;
    end

`ifdef WORK_LOADER_TIMEOUT_EN
    logic tmr_expired;
    logic drop_q;

    work_rx_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (bus.rx_valid || (state != RECV)),
        .enable  (state == RECV),
        .expired (tmr_expired)
    );
`endif

    // Loader FSM: byte assembly, atomic commit and start_mining hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hold_cnt   <= '0;
            asm_buf    <= '0;
            midstate_q <= '0;
            data2_q    <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef WORK_LOADER_TIMEOUT_EN
            drop_q     <= 1'b0;
`endif
        end else begin
`ifdef WORK_LOADER_TIMEOUT_EN
            drop_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        asm_buf[wr_idx] <= bus.rx_data;
                        cnt             <= cnt_inc;
                        busy_q          <= (cnt_inc != CNT_FULL);
                        state           <= (cnt_inc == CNT_FULL) ? COMMIT : RECV;
                    end
                end

                RECV: begin
`ifdef WORK_LOADER_TIMEOUT_EN
                    if (tmr_expired) begin
                        drop_q <= 1'b1;
                        if (bus.rx_valid) begin
                            asm_buf[0] <= bus.rx_data;
                            cnt        <= CNT_W'(1);
                        end else begin
                            cnt    <= '0;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end else
`endif
                    if (bus.rx_valid) begin
                        asm_buf[wr_idx] <= bus.rx_data;
                        cnt             <= cnt_inc;
                        if (cnt_inc == CNT_FULL) begin
                            busy_q <= 1'b0;
                            state  <= COMMIT;
                        end
                    end
                end

                COMMIT: begin
                    midstate_q <= buf_flat[MIDSTATE_LSB +: MIDSTATE_W];
                    data2_q    <= buf_flat[DATA2_LSB +: DATA2_W];
                    start_q    <= 1'b1;
                    hold_cnt   <= '0;
                    state      <= START;
                    // A byte here is already the head of the next packet.
                    if (bus.rx_valid) begin
                        asm_buf[0] <= bus.rx_data;
                        cnt        <= CNT_W'(1);
                        busy_q     <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end

                START: begin
                    if (take_start) begin
                        asm_buf[wr_idx] <= bus.rx_data;
                        cnt             <= cnt_inc;
                    end
                    busy_q <= (cnt_start != '0) && (cnt_start != CNT_FULL);
                    if (hold_cnt == HOLD_LAST) begin
                        start_q  <= 1'b0;
                        hold_cnt <= '0;
                        if (cnt_start == CNT_FULL)  state <= COMMIT;
                        else if (cnt_start != '0)   state <= RECV;
                        else                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.midstate     = midstate_q;
    assign bus.data2        = data2_q;
    assign bus.start_mining = start_q;
    assign bus.loader_busy  = busy_q;
`ifdef WORK_LOADER_TIMEOUT_EN
    assign bus.work_dropped = drop_q;
`else
    assign bus.work_dropped = 1'b0;
`endif

endmodule

// File: doc/work_loader.md
WORK_LOADER -- requirements
Module: work_loader

Interface
REQ-001 SHALL have parameter WORK_BYTES, default 64, bytes per work packet.
REQ-002 SHALL have parameter START_HOLD, default 4, cycles start_mining stays high.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 24'd10000000, max idle cycles between bytes of one packet.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-008 SHALL have port miner_busy  input  1  hashing core busy; status only, never blocks loading.
REQ-009 SHALL have port midstate  output  256  committed midstate to the hashing core.
REQ-010 SHALL have port data2  output  96  committed last 12 header bytes (merkle tail, time, bits).
REQ-011 SHALL have port start_mining  output  1  start request held START_HOLD cycles.
REQ-012 SHALL have port loader_busy  output  1  high while a packet is partially received.
REQ-013 SHALL have port work_dropped  output  1  one-cycle pulse when a partial packet is discarded.

Function
REQ-014 SHALL use states IDLE, RECV, COMMIT, START.
REQ-015 SHALL place byte k (0-based arrival order) at bits [8k+7:8k] of a 512-bit assembly buffer.
REQ-016 SHALL, on rx_valid in IDLE, store byte 0, set byte count to 1, go to RECV.
REQ-017 SHALL, on rx_valid in RECV, store byte at count and increment; the byte making count = WORK_BYTES moves to COMMIT.
REQ-018 SHALL, in COMMIT (one cycle), load midstate = buffer[255:0], data2 = buffer[511:416]; bytes 32..51 are ignored.
REQ-019 SHALL never change midstate/data2 except in COMMIT; a partial packet is never visible.
REQ-020 SHALL assert start_mining from the cycle after COMMIT for exactly START_HOLD cycles (state START), then return to IDLE.
REQ-021 SHALL, on rx_valid during START, accept it as byte 0 of the next packet (count = 1) while finishing the start_mining hold; START exits to RECV instead of IDLE.
REQ-022 SHALL accept new work regardless of miner_busy; the new start_mining restarts the core.
REQ-023 SHALL drive loader_busy high in RECV and in START when a next-packet byte is pending.
REQ-024 SHALL count bytes in a counter of width clog2(WORK_BYTES)+1; no wrap.

Reset
REQ-025 SHALL, on rst, asynchronously go to IDLE; count = 0; midstate = 0; data2 = 0; start_mining = 0; loader_busy = 0; work_dropped = 0.
REQ-026 SHALL, if rst asserts mid-packet or mid-hold, discard the packet and drop start_mining immediately without a work_dropped pulse.

Configuration
REQ-027 SHALL implement the inter-byte timeout only when WORK_LOADER_TIMEOUT_EN is defined.
REQ-028 SHALL, with WORK_LOADER_TIMEOUT_EN, discard a partial packet (count -> 0, state -> IDLE, one-cycle work_dropped) when TIMEOUT_CYCLES elapse in RECV with no rx_valid; the timer restarts on each accepted byte; rx_valid in the expiry cycle takes priority and is byte 0 of a new packet.
REQ-029 SHALL, without WORK_LOADER_TIMEOUT_EN, wait indefinitely in RECV, tie work_dropped to 0, and contain no timer logic.

Structure
REQ-030 SHALL keep state encodings, WORK_BYTES default, buffer bit offsets (MIDSTATE_LSB = 0, DATA2_LSB = 416) in shared package work_loader_pkg.
REQ-031 SHALL place the timeout counter in sub-module work_rx_timer (inputs clk, rst, restart, enable; output expired), instantiated only under WORK_LOADER_TIMEOUT_EN.

Verification
REQ-032 SHALL test: 64 bytes 0x00..0x3F back-to-back -> midstate = 0x1F1E..0100, data2 = 0x3F3E..3534, start_mining high 4 cycles starting 2 cycles after the last byte.
REQ-033 SHALL test: 30 bytes then rst -> all outputs 0, no start_mining, no work_dropped; a following 64-byte packet commits normally.
REQ-034 SHALL test (TIMEOUT_EN, TIMEOUT_CYCLES = 100): 10 bytes then 100 idle cycles -> one work_dropped pulse, midstate unchanged, next 64 bytes commit.
REQ-035 SHALL test: byte arrives on second start_mining cycle -> hold still lasts 4 cycles, loader_busy high, next packet completes after 63 more bytes.
REQ-036 SHALL test: packet sent with miner_busy = 1 -> outputs update and start_mining asserts identically.
REQ-037 SHALL test (no TIMEOUT_EN): 10 bytes, 10^6 idle cycles, 54 bytes -> single commit of all 64 bytes.
